// File: rtl/div_share_pkg.sv
// Shared definitions for the divider-sharing controller: default sizing,
// ID width derivation, the in-flight tag record and the divide-by-zero quotient.
package div_share_pkg;

    localparam int DEF_N           = 4;
    localparam int DEF_W           = 4;
    localparam int DEF_DIV_LATENCY = 4;

    // Tag fields are sized for the largest supported configuration
    // (up to 8 requesters, operands up to 32 bits). Narrower instances
    // zero-extend into them.
    localparam int TAG_ID_W  = 3;
    localparam int TAG_NUM_W = 32;

    // Quotient reported for a zero denominator, sliced to W by the user.
    localparam logic [TAG_NUM_W-1:0] DZ_QUOTIENT = {TAG_NUM_W{1'b1}};

    typedef struct packed {
        logic                 valid;
        logic [TAG_ID_W-1:0]  id;
        logic                 dz;
        logic [TAG_NUM_W-1:0] num;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0,
                                  id:    {TAG_ID_W{1'b0}},
                                  dz:    1'b0,
                                  num:   {TAG_NUM_W{1'b0}}};

    // Bits needed to hold a requester index 0..n-1 (at least one bit).
    function automatic int idw_of(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter. The search starts one past the last winner,
// so the most recently served requester has lowest priority next time.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid
);

    logic [IDW-1:0] ptr_r;
    logic [N-1:0]   grant_s;
    logic [IDW-1:0] grant_id_s;
    logic           found_s;
    int             idx_s;

    // Find the first valid requester after the pointer, wrapping modulo N.
    always_comb begin
        grant_s    = {N{1'b0}};
        grant_id_s = {IDW{1'b0}};
        found_s    = 1'b0;
        idx_s      = 0;
        for (int k = 1; k <= N; k++) begin
            idx_s      = (int'(ptr_r) + k) % N;
            grant_id_s = (req[idx_s] && !found_s) ? IDW'(idx_s) : grant_id_s;
            found_s    = found_s | req[idx_s];
        end
        if (enable && found_s) begin
            grant_s[grant_id_s] = 1'b1;
        end else begin
            grant_s = {N{1'b0}};
        end
    end

    assign grant       = grant_s;
    assign grant_id    = grant_id_s;
    assign grant_valid = enable & found_s;

    // Pointer follows the winner on a handshake and otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= IDW'(N - 1);
        end else if (enable && found_s) begin
            ptr_r <= grant_id_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one fully pipelined divider between N requesters. A round-robin
// arbiter picks one request per cycle; a tag pipe travels alongside the
// divider so each result leaves on the response bus with its owner's ID.
// Zero denominators are resolved from the tag, ignoring the divider output.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int W           = DEF_W,
    parameter int DIV_LATENCY = DEF_DIV_LATENCY,
    parameter int IDW         = idw_of(N)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           ENABLE,
    input  logic [N-1:0]   REQ_VALID,
    output logic [N-1:0]   REQ_READY,
    input  logic [N*W-1:0] REQ_NUM,
    input  logic [N*W-1:0] REQ_DEN,
    output logic [W-1:0]   DIV_NUM,
    output logic [W-1:0]   DIV_DEN,
    input  logic [W-1:0]   DIV_Q,
    input  logic [W-1:0]   DIV_R,
    output logic           RSP_VALID,
    output logic [IDW-1:0] RSP_ID,
    output logic [W-1:0]   RSP_Q,
    output logic [W-1:0]   RSP_R,
    output logic           RSP_DZ,
    output logic           BUSY
);

    logic [IDW-1:0] grant_id_s;
    logic           grant_valid_s;
    logic [W-1:0]   sel_num_s;
    logic [W-1:0]   sel_den_s;
    tag_t           tag_next_s;
    tag_t           last_tag_s;
    logic           any_tag_s;
    logic           unused_tag_bits_s;

    // Stage 0 is captured together with the divider operands; stage
    // DIV_LATENCY lines up with the divider result.
    tag_t           tag_pipe_r [0:DIV_LATENCY];

    logic [W-1:0]   div_num_r;
    logic [W-1:0]   div_den_r;
    logic           rsp_valid_r;
    logic [IDW-1:0] rsp_id_r;
    logic [W-1:0]   rsp_q_r;
    logic [W-1:0]   rsp_r_r;
    logic           rsp_dz_r;
    logic           busy_r;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .clk         (CLK),
        .rst_n       (RST_N),
        .enable      (ENABLE),
        .req         (REQ_VALID),
        .grant       (REQ_READY),
        .grant_id    (grant_id_s),
        .grant_valid (grant_valid_s)
    );

    // Select the winner's operands and build the tag that follows them.
    always_comb begin
        sel_num_s  = REQ_NUM[int'(grant_id_s)*W +: W];
        sel_den_s  = REQ_DEN[int'(grant_id_s)*W +: W];
        tag_next_s = TAG_IDLE;
        if (grant_valid_s) begin
            tag_next_s.valid = 1'b1;
            tag_next_s.id    = TAG_ID_W'(grant_id_s);
            tag_next_s.dz    = (sel_den_s == {W{1'b0}});
            tag_next_s.num   = TAG_NUM_W'(sel_num_s);
        end else begin
            tag_next_s = TAG_IDLE;
        end
    end

    // Divider operands load only on a handshake and hold otherwise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_num_r <= {W{1'b0}};
            div_den_r <= {W{1'b0}};
        end else if (grant_valid_s) begin
            div_num_r <= sel_num_s;
            div_den_r <= sel_den_s;
        end else begin
            div_num_r <= div_num_r;
            div_den_r <= div_den_r;
        end
    end

    // Tag pipe shifts every cycle; the divider has no backpressure.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i <= DIV_LATENCY; i++) begin
                tag_pipe_r[i] <= TAG_IDLE;
            end
        end else begin
            tag_pipe_r[0] <= tag_next_s;
            for (int i = 1; i <= DIV_LATENCY; i++) begin
                tag_pipe_r[i] <= tag_pipe_r[i-1];
            end
        end
    end

    assign last_tag_s = tag_pipe_r[DIV_LATENCY];

    // Tag bits above W/IDW are always zero; fold them into a sink.
    assign unused_tag_bits_s = ^last_tag_s;

    // Any valid tag anywhere in the pipe means work is outstanding.
    always_comb begin
        any_tag_s = 1'b0;
        for (int i = 0; i <= DIV_LATENCY; i++) begin
            any_tag_s = any_tag_s | tag_pipe_r[i].valid;
        end
    end

    // Response register: pulse valid, hold payload between responses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_q_r     <= {W{1'b0}};
            rsp_r_r     <= {W{1'b0}};
            rsp_dz_r    <= 1'b0;
        end else begin
            rsp_valid_r <= last_tag_s.valid;
            if (last_tag_s.valid) begin
                rsp_id_r <= last_tag_s.id[IDW-1:0];
                if (last_tag_s.dz) begin
                    rsp_q_r  <= DZ_QUOTIENT[W-1:0];
                    rsp_r_r  <= last_tag_s.num[W-1:0];
                    rsp_dz_r <= 1'b1;
                end else begin
                    rsp_q_r  <= DIV_Q;
                    rsp_r_r  <= DIV_R;
                    rsp_dz_r <= 1'b0;
                end
            end else begin
                rsp_id_r <= rsp_id_r;
                rsp_q_r  <= rsp_q_r;
                rsp_r_r  <= rsp_r_r;
                rsp_dz_r <= rsp_dz_r;
            end
        end
    end

    // BUSY lags the tag pipe by one cycle, which also covers the response cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= any_tag_s;
        end
    end

    assign DIV_NUM   = div_num_r;
    assign DIV_DEN   = div_den_r;
    assign RSP_VALID = rsp_valid_r;
    assign RSP_ID    = rsp_id_r;
    assign RSP_Q     = rsp_q_r;
    assign RSP_R     = rsp_r_r;
    assign RSP_DZ    = rsp_dz_r;
    assign BUSY      = busy_r;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: a behavioural pipelined divider, a queue-based
// reference model of arbitration and responses, a directed vector table,
// hand-written reset sequences and a randomized phase.
module tb_div_share_ctrl;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int L   = 4;
    localparam int IDW = 2;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           ENABLE = 1'b0;
    logic [N-1:0]   REQ_VALID = '0;
    logic [N-1:0]   REQ_READY;
    logic [N*W-1:0] REQ_NUM = '0;
    logic [N*W-1:0] REQ_DEN = '0;
    logic [W-1:0]   DIV_NUM, DIV_DEN, DIV_Q, DIV_R;
    logic           RSP_VALID, RSP_DZ, BUSY;
    logic [IDW-1:0] RSP_ID;
    logic [W-1:0]   RSP_Q, RSP_R;

    div_share_ctrl #(.N(N), .W(W), .DIV_LATENCY(L), .IDW(IDW)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_NUM(REQ_NUM), .REQ_DEN(REQ_DEN),
        .DIV_NUM(DIV_NUM), .DIV_DEN(DIV_DEN), .DIV_Q(DIV_Q), .DIV_R(DIV_R),
        .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_Q(RSP_Q), .RSP_R(RSP_R),
        .RSP_DZ(RSP_DZ), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural divider with L cycles of latency; junk on zero denominator.
    logic [W-1:0] dq_pipe [0:L-1] = '{default: 4'h0};
    logic [W-1:0] dr_pipe [0:L-1] = '{default: 4'h0};
    always @(posedge CLK) begin
        dq_pipe[0] <= (DIV_DEN == 4'h0) ? 4'hA : DIV_NUM / DIV_DEN;
        dr_pipe[0] <= (DIV_DEN == 4'h0) ? 4'h3 : DIV_NUM % DIV_DEN;
        for (int i = 1; i < L; i++) begin
            dq_pipe[i] <= dq_pipe[i-1];
            dr_pipe[i] <= dr_pipe[i-1];
        end
    end
    assign DIV_Q = dq_pipe[L-1];
    assign DIV_R = dr_pipe[L-1];

    // Reference model state
    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;
    exp_t         exp_q[$];
    int           ptr_m;
    int           edge_n;
    logic [IDW-1:0] last_id;
    logic [W-1:0] last_q, last_r;
    logic         last_dz;
    logic [W-1:0] div_num_m, div_den_m, pend_num, pend_den;
    logic         hs_pend;
    int           tests = 0;
    int           fails = 0;

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*W-1:0] num;
        logic [N*W-1:0] den;
        logic           en;
        logic [N-1:0]   exp_ready;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
        logic [N*W-1:0] v;
        v = {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
        return v;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        ptr_m = N - 1;
        last_id = '0; last_q = '0; last_r = '0; last_dz = 1'b0;
        div_num_m = '0; div_den_m = '0; hs_pend = 1'b0;
    endtask

    // Apply inputs, let them settle, check the grant and record any handshake.
    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] nums,
                         input logic [N*W-1:0] dens, input logic en);
        int g;
        logic [W-1:0] n, d;
        REQ_VALID = v; REQ_NUM = nums; REQ_DEN = dens; ENABLE = en;
        #1;
        g = -1;
        if (en) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            end
        end
        chk("req_ready", 32'(REQ_READY), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
            ptr_m = g;
            n = nums[g*W +: W];
            d = dens[g*W +: W];
            pend_num = n; pend_den = d; hs_pend = 1'b1;
            exp_q.push_back('{due: edge_n + L + 2, id: g,
                              q: (d == 0) ? 4'hF : n / d,
                              r: (d == 0) ? n : n % d,
                              dz: (d == 0)});
        end
    endtask

    // Advance one edge and compare every registered output with the model.
    task automatic tick();
        logic exp_valid, exp_busy;
        exp_t e;
        @(posedge CLK);
        edge_n++;
        #1;
        if (hs_pend) begin
            div_num_m = pend_num; div_den_m = pend_den; hs_pend = 1'b0;
        end
        exp_busy = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].due - L - 1 < edge_n) exp_busy = 1'b1;
        exp_valid = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
            e = exp_q.pop_front();
            exp_valid = 1'b1;
            last_id = IDW'(e.id); last_q = e.q; last_r = e.r; last_dz = e.dz;
        end
        chk("rsp_valid", 32'(RSP_VALID), 32'(exp_valid));
        chk("rsp_id", 32'(RSP_ID), 32'(last_id));
        chk("rsp_q", 32'(RSP_Q), 32'(last_q));
        chk("rsp_r", 32'(RSP_R), 32'(last_r));
        chk("rsp_dz", 32'(RSP_DZ), 32'(last_dz));
        chk("busy", 32'(BUSY), 32'(exp_busy));
        chk("div_num", 32'(DIV_NUM), 32'(div_num_m));
        chk("div_den", 32'(DIV_DEN), 32'(div_den_m));
    endtask

    task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] nums,
                       input logic [N*W-1:0] dens, input logic en);
        drive(v, nums, dens, en);
        tick();
    endtask

    task automatic check_reset_outputs();
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_rsp_id", 32'(RSP_ID), 32'd0);
        chk("rst_rsp_q", 32'(RSP_Q), 32'd0);
        chk("rst_rsp_r", 32'(RSP_R), 32'd0);
        chk("rst_rsp_dz", 32'(RSP_DZ), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_div_num", 32'(DIV_NUM), 32'd0);
        chk("rst_div_den", 32'(DIV_DEN), 32'd0);
        chk("rst_ready", 32'(REQ_READY), 32'd0);
    endtask

    // Asynchronous reset asserted between edges, released between edges.
    task automatic do_reset();
        REQ_VALID = '0; ENABLE = 1'b0;
        RST_N = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge CLK); edge_n++;
        @(posedge CLK); edge_n++;
        #2;
        check_reset_outputs();
        RST_N = 1'b1;
    endtask

    task automatic add(input logic [N-1:0] v, input logic [N*W-1:0] nums,
                       input logic [N*W-1:0] dens, input logic en, input logic [N-1:0] er);
        vecs.push_back('{valid: v, num: nums, den: dens, en: en, exp_ready: er});
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(4'b0000, '0, '0, 1'b1, 4'b0000);
    endtask

    initial begin
        logic [N*W-1:0] ops_n, ops_d, t3_n, t3_d;
        edge_n = 0;
        model_reset();

        // Vector table (applied after a fresh reset, pointer at N-1)
        ops_n = pk(9, 5, 8, 7);
        ops_d = pk(3, 2, 2, 7);
        for (int i = 0; i < 5; i++) add(4'b1111, ops_n, ops_d, 1'b1, 4'(1 << (i % 4)));
        add_idle(6);
        t3_n = pk(0, 9, 5, 8);
        t3_d = pk(0, 3, 0, 2);
        add(4'b1110, t3_n, t3_d, 1'b1, 4'b0010);
        add(4'b1100, t3_n, t3_d, 1'b1, 4'b0100);
        add(4'b1000, t3_n, t3_d, 1'b1, 4'b1000);
        add_idle(6);
        add(4'b1111, ops_n, ops_d, 1'b1, 4'b0001);
        add(4'b1111, ops_n, ops_d, 1'b1, 4'b0010);
        for (int i = 0; i < 7; i++) add(4'b1111, ops_n, ops_d, 1'b0, 4'b0000);
        add(4'b1111, ops_n, ops_d, 1'b1, 4'b0100);
        add_idle(6);
        for (int i = 0; i < 3; i++) add(4'b1000, ops_n, ops_d, 1'b1, 4'b1000);
        add(4'b0101, ops_n, ops_d, 1'b0, 4'b0000);
        add(4'b1111, ops_n, ops_d, 1'b1, 4'b0001);
        add_idle(6);

        // Reset state
        #3;
        check_reset_outputs();
        #9;
        RST_N = 1'b1;

        // Single request: 7/7 from requester 0
        cyc(4'b0001, pk(7, 0, 0, 0), pk(7, 0, 0, 0), 1'b1);
        for (int i = 0; i < 7; i++) cyc(4'b0000, '0, '0, 1'b1);

        // Directed vector table
        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].num, vecs[i].den, vecs[i].en);
            chk("tbl_ready", 32'(REQ_READY), 32'(vecs[i].exp_ready));
            tick();
        end

        // Reset with three operations in flight; no response may follow
        for (int i = 0; i < 3; i++) cyc(4'b1111, ops_n, ops_d, 1'b1);
        do_reset();
        for (int i = 0; i < L + 3; i++) cyc(4'b0000, '0, '0, 1'b1);
        cyc(4'b1111, ops_n, ops_d, 1'b1);
        for (int i = 0; i < L + 2; i++) cyc(4'b0000, '0, '0, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                ($urandom_range(0, 7) != 0));
        end
        for (int i = 0; i < L + 3; i++) cyc(4'b0000, '0, '0, 1'b1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
